dpdm_xcvr: RTL and testbench

- Parametrised successor to the host-side DP/DM line stage. It sits between the bit-level encode/decode pipelines and the USB D+/D- pins.
- TX path: generates SYNC itself from a parameter, serialises bits with a valid/ready handshake, ends frame on tx_last, appends a configurable EOP.
- RX path: detects a parametrised SYNC, delivers bits, validates EOP length and flags line errors.
- TX and RX operate independently; the protocol FSM gates RX with rx_en.

---
 rtl/dpdm_pkg.sv | 35 +++
 rtl/dpdm_rx.sv | 165 ++++++++++++++++
 rtl/dpdm_xcvr.sv | 165 ++++++++++++++++
 tb/tb_dpdm_xcvr.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpdm_pkg.sv
// Shared definitions for the DP/DM line stage: line-state encodings,
// FSM state types, default SYNC pattern and a counter-sizing helper.
// Optional build macro used by this block: DPDM_RX_TIMEOUT_EN.
package dpdm_pkg;

    // {dp, dm} line states
    localparam logic [1:0] LS_IDLE = 2'b10;
    localparam logic [1:0] LS_SE0  = 2'b00;
    localparam logic [1:0] LS_SE1  = 2'b11;

    localparam logic [7:0] SYNC_DEFAULT = 8'b0101_0100;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SYNC,
        T_DATA,
        T_SE0,
        T_EOPJ
    } tx_state_t;

    typedef enum logic [1:0] {
        R_SEEK,
        R_DATA,
        R_EOP
    } rx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/dpdm_rx.sv
// Receive half of the DP/DM line stage: SYNC search, bit delivery,
// EOP length validation and line-error reporting.
// Optional build macro: DPDM_RX_TIMEOUT_EN adds an idle-line timeout
// on rx_timeout; without it rx_timeout is tied low.
//
// state  | meaning
// R_SEEK | shifting dp_r looking for a full SYNC match
// R_DATA | delivering data symbols, counting rx_len
// R_EOP  | inside SE0, checking EOP length before the closing IDLE
module dpdm_rx
    import dpdm_pkg::*;
#(
    parameter int                     SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0]    SYNC_PATTERN = SYNC_LEN'(SYNC_DEFAULT),
    parameter int                     EOP_SE0      = 2,
    parameter int                     LEN_W        = 7,
    parameter int                     TIMEOUT_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             rx_en,
    input  logic             dp_r,
    input  logic             dm_r,
    output logic             rx_bit,
    output logic             rx_valid,
    output logic             rx_done,
    output logic             rx_err,
    output logic [LEN_W-1:0] rx_len,
    output logic             rx_timeout
);

    localparam int CNT_W = $clog2(max3(SYNC_LEN, EOP_SE0, 1) + 1);
    localparam logic [CNT_W-1:0] SEEK_LOAD = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] EOP_LOAD  = CNT_W'(EOP_SE0 - 1);

    rx_state_t           rx_state_q;
    logic [SYNC_LEN-1:0] sync_sr_q;
    logic [SYNC_LEN-1:0] sync_sr_d;
    logic [CNT_W-1:0]    seek_cnt_q;
    logic [CNT_W-1:0]    eop_cnt_q;
    logic                rx_bit_q;
    logic                rx_valid_q;
    logic                rx_done_q;
    logic                rx_err_q;
    logic [LEN_W-1:0]    rx_len_q;
    logic [1:0]          line;
    logic                is_data;
    logic                sync_hit;

    assign line      = {dp_r, dm_r};
    assign is_data   = dp_r ^ dm_r;
    assign sync_sr_d = (sync_sr_q << 1) | SYNC_LEN'(dp_r);
    // seek_cnt_q counts down the symbols still needed before the shift
    // register holds SYNC_LEN fresh samples, so cleared zeros never match.
    assign sync_hit  = is_data && (seek_cnt_q == '0) && (sync_sr_d == SYNC_PATTERN);

    // RX protocol FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rx_state_q <= R_SEEK;
            sync_sr_q  <= '0;
            seek_cnt_q <= SEEK_LOAD;
            eop_cnt_q  <= '0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_len_q   <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
            if (!rx_en) begin
                rx_state_q <= R_SEEK;
                sync_sr_q  <= '0;
                seek_cnt_q <= SEEK_LOAD;
            end else begin
                unique case (rx_state_q)
                    R_SEEK: begin
                        if (!is_data) begin
                            sync_sr_q  <= '0;
                            seek_cnt_q <= SEEK_LOAD;
                        end else if (sync_hit) begin
                            rx_state_q <= R_DATA;
                            rx_len_q   <= '0;
                            sync_sr_q  <= '0;
                            seek_cnt_q <= SEEK_LOAD;
                        end else begin
                            sync_sr_q <= sync_sr_d;
                            if (seek_cnt_q != '0) seek_cnt_q <= seek_cnt_q - CNT_W'(1);
                        end
                    end
                    R_DATA: begin
                        if (is_data) begin
                            rx_valid_q <= 1'b1;
                            rx_bit_q   <= dp_r;
                            if (!(&rx_len_q)) rx_len_q <= rx_len_q + LEN_W'(1);
                        end else if (line == LS_SE0) begin
                            rx_state_q <= R_EOP;
                            eop_cnt_q  <= EOP_LOAD;
                        end else begin
                            rx_err_q   <= 1'b1;
                            rx_state_q <= R_SEEK;
                        end
                    end
                    R_EOP: begin
                        // eop_cnt_q holds SE0 cycles still expected
                        if (line == LS_SE0) begin
                            if (eop_cnt_q == '0) begin
                                rx_err_q   <= 1'b1;
                                rx_state_q <= R_SEEK;
                            end else begin
                                eop_cnt_q <= eop_cnt_q - CNT_W'(1);
                            end
                        end else if ((line == LS_IDLE) && (eop_cnt_q == '0)) begin
                            rx_done_q  <= 1'b1;
                            rx_state_q <= R_SEEK;
                        end else begin
                            rx_err_q   <= 1'b1;
                            rx_state_q <= R_SEEK;
                        end
                    end
                    default: rx_state_q <= R_SEEK;
                endcase
            end
        end
    end

    assign rx_bit   = rx_bit_q;
    assign rx_valid = rx_valid_q;
    assign rx_done  = rx_done_q;
    assign rx_err   = rx_err_q;
    assign rx_len   = rx_len_q;

`ifdef DPDM_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            rx_timeout_q;

    // Idle-line timeout: counts down only while enabled and searching
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            to_cnt_q     <= TO_LOAD;
            rx_timeout_q <= 1'b0;
        end else begin
            rx_timeout_q <= 1'b0;
            if (!rx_en || (rx_state_q != R_SEEK) || sync_hit) begin
                to_cnt_q <= TO_LOAD;
            end else if (to_cnt_q == '0) begin
                rx_timeout_q <= 1'b1;
                to_cnt_q     <= TO_LOAD;
            end else begin
                to_cnt_q <= to_cnt_q - TO_W'(1);
            end
        end
    end

    assign rx_timeout = rx_timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: rtl/dpdm_xcvr.sv
// Host-side DP/DM line stage. The TX serialiser lives here; the receive
// half is dpdm_rx. TX and RX run independently.
// Optional build macro: DPDM_RX_TIMEOUT_EN (enables rx_timeout).
//
// state  | meaning
// T_IDLE | line IDLE, waiting for tx_valid (bit not consumed)
// T_SYNC | shifting out SYNC_PATTERN MSB-first
// T_DATA | tx_ready high, one accepted bit per cycle
// T_SE0  | SE0 portion of the EOP
// T_EOPJ | IDLE portion of the EOP, tx_valid ignored
module dpdm_xcvr
    import dpdm_pkg::*;
#(
    parameter int                     SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0]    SYNC_PATTERN = SYNC_LEN'(SYNC_DEFAULT),
    parameter int                     EOP_SE0      = 2,
    parameter int                     EOP_IDLE     = 1,
    parameter int                     LEN_W        = 7,
    parameter int                     TIMEOUT_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             tx_bit,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_underrun,
    output logic             dp_w,
    output logic             dm_w,
    input  logic             rx_en,
    input  logic             dp_r,
    input  logic             dm_r,
    output logic             rx_bit,
    output logic             rx_valid,
    output logic             rx_done,
    output logic             rx_err,
    output logic [LEN_W-1:0] rx_len,
    output logic             rx_timeout
);

    localparam int CNT_W = $clog2(max3(SYNC_LEN, EOP_SE0, EOP_IDLE) + 1);
    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] SE0_LOAD  = CNT_W'(EOP_SE0 - 1);
    // On underrun the abort cycle itself already drives SE0, so T_SE0
    // runs one cycle shorter to keep the SE0 run at EOP_SE0.
    localparam logic [CNT_W-1:0] SE0_ABORT_LOAD = CNT_W'((EOP_SE0 > 1) ? EOP_SE0 - 2 : 0);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(EOP_IDLE - 1);

    tx_state_t           tx_state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SYNC_LEN-1:0] sync_sr_q;
    logic                dp_w_q;
    logic                dm_w_q;
    logic                tx_ready_q;
    logic                tx_busy_q;
    logic                tx_underrun_q;

    // TX FSM: line symbols are registered, so each symbol chosen in a
    // cycle appears on dp_w/dm_w the following cycle
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            tx_state_q    <= T_IDLE;
            cnt_q         <= '0;
            sync_sr_q     <= '0;
            dp_w_q        <= 1'b1;
            dm_w_q        <= 1'b0;
            tx_ready_q    <= 1'b0;
            tx_busy_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            unique case (tx_state_q)
                T_IDLE: begin
                    {dp_w_q, dm_w_q} <= LS_IDLE;
                    if (tx_valid) begin
                        tx_state_q <= T_SYNC;
                        cnt_q      <= SYNC_LOAD;
                        sync_sr_q  <= SYNC_PATTERN;
                        tx_busy_q  <= 1'b1;
                    end
                end
                T_SYNC: begin
                    dp_w_q    <= sync_sr_q[SYNC_LEN-1];
                    dm_w_q    <= ~sync_sr_q[SYNC_LEN-1];
                    sync_sr_q <= sync_sr_q << 1;
                    if (cnt_q == '0) begin
                        tx_state_q <= T_DATA;
                        tx_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                T_DATA: begin
                    if (tx_valid && tx_ready_q) begin
                        dp_w_q <= tx_bit;
                        dm_w_q <= ~tx_bit;
                        if (tx_last) begin
                            tx_state_q <= T_SE0;
                            cnt_q      <= SE0_LOAD;
                            tx_ready_q <= 1'b0;
                        end
                    end else begin
                        tx_underrun_q    <= 1'b1;
                        {dp_w_q, dm_w_q} <= LS_SE0;
                        tx_state_q       <= T_SE0;
                        cnt_q            <= SE0_ABORT_LOAD;
                        tx_ready_q       <= 1'b0;
                    end
                end
                T_SE0: begin
                    {dp_w_q, dm_w_q} <= LS_SE0;
                    if (cnt_q == '0) begin
                        tx_state_q <= T_EOPJ;
                        cnt_q      <= IDLE_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                T_EOPJ: begin
                    {dp_w_q, dm_w_q} <= LS_IDLE;
                    if (cnt_q == '0) begin
                        tx_state_q <= T_IDLE;
                        tx_busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    tx_state_q       <= T_IDLE;
                    {dp_w_q, dm_w_q} <= LS_IDLE;
                    tx_ready_q       <= 1'b0;
                    tx_busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign dp_w        = dp_w_q;
    assign dm_w        = dm_w_q;
    assign tx_ready    = tx_ready_q;
    assign tx_busy     = tx_busy_q;
    assign tx_underrun = tx_underrun_q;

    dpdm_rx #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN),
        .EOP_SE0      (EOP_SE0),
        .LEN_W        (LEN_W),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_b      (rst_b),
        .rx_en      (rx_en),
        .dp_r       (dp_r),
        .dm_r       (dm_r),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_len     (rx_len),
        .rx_timeout (rx_timeout)
    );

endmodule

// File: tb/tb_dpdm_xcvr.sv
// Self-checking bench for dpdm_xcvr: TX line symbols and received bits
// are queued when stimulus is driven and compared when the DUT emits them.
// Optional build macro: DPDM_RX_TIMEOUT_EN enables the timeout scenario.
module tb_dpdm_xcvr;
    import dpdm_pkg::*;

    localparam logic [7:0] SYNC_TB = 8'b0101_0100;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       tx_bit, tx_valid, tx_last;
    logic       tx_ready, tx_busy, tx_underrun;
    logic       dp_w, dm_w;
    logic       rx_en;
    logic       dp_r, dm_r;
    logic       rx_bit, rx_valid, rx_done, rx_err, rx_timeout;
    logic [6:0] rx_len;

    logic loop_en, dp_drv, dm_drv;
    assign dp_r = loop_en ? dp_w : dp_drv;
    assign dm_r = loop_en ? dm_w : dm_drv;

    dpdm_xcvr dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .tx_bit      (tx_bit),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun),
        .dp_w        (dp_w),
        .dm_w        (dm_w),
        .rx_en       (rx_en),
        .dp_r        (dp_r),
        .dm_r        (dm_r),
        .rx_bit      (rx_bit),
        .rx_valid    (rx_valid),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .rx_len      (rx_len),
        .rx_timeout  (rx_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [1:0] line_q[$];
    logic       rx_q[$];
    bit         line_started = 0;
    bit         rx_mon_en = 1;
    int         done_cnt = 0, err_cnt = 0, und_cnt = 0, to_cnt = 0;

    // Output monitors: sample on the falling edge
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (rx_done)     done_cnt++;
            if (rx_err)      err_cnt++;
            if (tx_underrun) und_cnt++;
            if (rx_timeout)  to_cnt++;
            if (rx_valid && rx_mon_en) begin
                check_eq("rx_pending", 32'(rx_q.size() != 0), 1);
                if (rx_q.size() != 0) check_eq("rx_bit", rx_bit, rx_q.pop_front());
            end
            if (line_q.size() != 0) begin
                if (!line_started && ({dp_w, dm_w} != LS_IDLE)) line_started = 1;
                if (line_started) begin
                    check_eq("tx_line", {dp_w, dm_w}, line_q.pop_front());
                    if (line_q.size() == 0) begin
                        line_started = 0;
                        check_eq("tx_busy_end", tx_busy, 0);
                    end
                end
            end
        end
    end

    task automatic expect_rx(input int d0, input int e0, input int u0,
                             input int exp_done, input int exp_err, input int exp_und,
                             input int exp_len);
        int guard = 0;
        while (done_cnt == d0 && err_cnt == e0 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check_eq("rx_done_cnt", done_cnt - d0, exp_done);
        check_eq("rx_err_cnt", err_cnt - e0, exp_err);
        check_eq("tx_underrun_cnt", und_cnt - u0, exp_und);
        check_eq("rx_len", rx_len, exp_len);
        check_eq("rx_q_empty", rx_q.size(), 0);
    endtask

    // Transmit nsend of nbits random bits in loopback; nsend < nbits underruns
    task automatic tx_frame(input int nbits, input int nsend);
        logic [7:0] sp;
        logic       bits[$];
        int         i, guard, d0, e0, u0;
        sp = SYNC_TB;
        d0 = done_cnt; e0 = err_cnt; u0 = und_cnt;
        loop_en = 1;
        for (int k = 0; k < nbits; k++) bits.push_back(1'($urandom_range(0, 1)));
        for (int k = 7; k >= 0; k--) line_q.push_back({sp[k], ~sp[k]});
        for (int k = 0; k < nsend; k++) line_q.push_back({bits[k], ~bits[k]});
        line_q.push_back(LS_SE0);
        line_q.push_back(LS_SE0);
        line_q.push_back(LS_IDLE);
        i = 0; guard = 0;
        while (i < nsend && guard < 300) begin
            @(negedge clk);
            tx_valid = 1; tx_bit = bits[i]; tx_last = (i == nbits - 1);
            if (tx_ready) begin
                rx_q.push_back(bits[i]);
                i++;
            end
            guard++;
        end
        check_eq("tx_accepted", i, nsend);
        @(negedge clk);
        tx_valid = 0; tx_last = 0; tx_bit = 0;
        guard = 0;
        while (line_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("tx_line_drained", line_q.size(), 0);
        expect_rx(d0, e0, u0, 1, 0, (nsend < nbits) ? 1 : 0, nsend);
    endtask

    task automatic drive_sym(input logic [1:0] s);
        @(negedge clk);
        {dp_drv, dm_drv} = s;
    endtask

    // Directly driven RX packet; tail 0 = good EOP, 1 = SE1, 2 = three SE0
    task automatic rx_frame(input int nbits, input int tail);
        logic [7:0] sp;
        logic       b;
        int         d0, e0, u0;
        sp = SYNC_TB;
        d0 = done_cnt; e0 = err_cnt; u0 = und_cnt;
        {dp_drv, dm_drv} = LS_IDLE;
        loop_en = 0;
        repeat (3) drive_sym(LS_IDLE);
        for (int k = 7; k >= 0; k--) drive_sym({sp[k], ~sp[k]});
        for (int k = 0; k < nbits; k++) begin
            b = 1'($urandom_range(0, 1));
            rx_q.push_back(b);
            drive_sym({b, ~b});
        end
        case (tail)
            0: begin drive_sym(LS_SE0); drive_sym(LS_SE0); end
            1: drive_sym(LS_SE1);
            default: begin drive_sym(LS_SE0); drive_sym(LS_SE0); drive_sym(LS_SE0); end
        endcase
        repeat (3) drive_sym(LS_IDLE);
        expect_rx(d0, e0, u0, (tail == 0) ? 1 : 0, (tail == 0) ? 0 : 1, 0,
                  (nbits > 127) ? 127 : nbits);
        loop_en = 1;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, {dp_w, dm_w, tx_ready, tx_busy, tx_underrun,
                       rx_valid, rx_done, rx_err, rx_bit, rx_len}, {9'b1_0000_0000, 7'd0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_b = 0; tx_bit = 0; tx_valid = 0; tx_last = 0;
        rx_en = 0; loop_en = 1; dp_drv = 1; dm_drv = 0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset_initial");
        rst_b = 1; rx_en = 1;
        repeat (4) @(negedge clk);

        tx_frame(16, 16);
        tx_frame(32, 32);
        tx_frame(100, 5);

        rx_frame(10, 1);
        rx_frame(12, 2);
        rx_frame(20, 0);
        rx_frame(130, 0);

`ifdef DPDM_RX_TIMEOUT_EN
        rx_mon_en = 0; loop_en = 0; {dp_drv, dm_drv} = LS_IDLE;
        @(negedge clk) rx_en = 0;
        @(negedge clk) rx_en = 1;
        t0 = to_cnt;
        repeat (130) @(negedge clk);
        check_eq("timeout_pulses", to_cnt - t0, 2);
        @(negedge clk) rx_en = 0;
        @(negedge clk) rx_en = 1;
        t0 = to_cnt;
        repeat (31) drive_sym(LS_IDLE);
        for (int k = 7; k >= 0; k--) drive_sym({SYNC_TB[k], ~SYNC_TB[k]});
        repeat (100) drive_sym(LS_IDLE);
        check_eq("timeout_after_sync", to_cnt - t0, 0);
        @(negedge clk) rx_en = 0;
        rx_q.delete();
        @(negedge clk) rx_en = 1;
        loop_en = 1; rx_mon_en = 1;
        repeat (3) @(negedge clk);
`else
        t0 = to_cnt;
        check_eq("timeout_tied_low", t0, 0);
`endif

        // Reset in the middle of a transmitted packet
        rx_mon_en = 0;
        @(negedge clk);
        tx_valid = 1; tx_last = 0;
        for (int k = 0; k < 20; k++) begin
            tx_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_eq("busy_before_reset", tx_busy, 1);
        rst_b = 0; tx_valid = 0;
        repeat (3) @(negedge clk);
        rst_b = 1;
        @(negedge clk);
        check_reset_outs("reset_mid_tx");
        rx_q.delete();
        rx_mon_en = 1;
        repeat (2) @(negedge clk);
        tx_frame(8, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
